// File: rtl/rps4_req_ctrl.sv
// rps4_req_ctrl: request-side controller for a downstream 4-way rps4 arbiter.
// Counts pending work per requester, presents req/en to the arbiter, accepts
// a legal grant each cycle and holds the shared resource busy for
// SERVICE_CYCLES cycles after each accepted grant.
//
// Ports:
//   clock     - single clock, rising-edge state updates
//   reset     - synchronous active-high reset
//   post      - [0:3] one-cycle work-request pulses, any number of bits
//   gnt       - [0:3] grant vector from rps4 (combinational on req/en)
//   req       - [0:3] requester i has pending work
//   en        - resource free (busy timer is zero)
//   pend_cnt  - [0:7] packed 2-bit counters, bits [2i:2i+1] = requester i
//   overflow  - [0:3] sticky, a post was dropped at saturation
//   served_id - [0:1] index of the most recently accepted grant
//   err       - sticky protocol-violation flag
module rps4_req_ctrl #(
  parameter int unsigned SERVICE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [0:3] post,
  input  logic [0:3] gnt,
  output logic [0:3] req,
  output logic       en,
  output logic [0:7] pend_cnt,
  output logic [0:3] overflow,
  output logic [0:1] served_id,
  output logic       err
);

  localparam logic [3:0] ServiceLoad = 4'(SERVICE_CYCLES);

  logic [1:0] cnt_q [4];
  logic [1:0] cnt_d [4];
  logic [3:0] timer_q, timer_d;
  logic [0:3] ovf_q, ovf_d;
  logic [0:1] sid_q, sid_d;
  logic       err_q, err_d;

  logic gnt_any, gnt_onehot, gnt_unreq, violation, accept;

  // Outputs are pure functions of registered state.
  always_comb begin
    req      = '0;
    pend_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      req[i]            = (cnt_q[i] != 2'd0);
      pend_cnt[2*i +: 2] = cnt_q[i];
    end
  end

  assign en        = (timer_q == 4'd0);
  assign overflow  = ovf_q;
  assign served_id = sid_q;
  assign err       = err_q;

  // Grant legality: one-hot test is independent of the [0:3] bit ordering.
  assign gnt_any    = (gnt != 4'b0000);
  assign gnt_onehot = ((gnt & (gnt - 4'd1)) == 4'b0000);
  assign gnt_unreq  = ((gnt & ~req) != 4'b0000);
  assign violation  = gnt_any && (!en || !gnt_onehot || gnt_unreq);
  assign accept     = gnt_any && !violation;

  always_comb begin
    timer_d = (timer_q != 4'd0) ? timer_q - 4'd1 : timer_q;
    ovf_d   = ovf_q;
    sid_d   = sid_q;
    err_d   = err_q | violation;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
    end

    if (accept) begin
      timer_d = ServiceLoad;
    end

    for (int i = 0; i < 4; i++) begin
      if (accept && gnt[i]) begin
        sid_d = 2'(i);
        // A post arriving with its own grant cancels the decrement.
        if (!post[i]) begin
          cnt_d[i] = cnt_q[i] - 2'd1;
        end
      end else if (post[i]) begin
        if (cnt_q[i] == 2'd3) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 2'd0;
      end
      timer_q <= 4'd0;
      ovf_q   <= 4'b0000;
      sid_q   <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
      sid_q   <= sid_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/rps4_req_ctrl.md
RPS4_REQ_CTRL -- requirements
Module: rps4_req_ctrl

Interface
REQ-001 Parameter SERVICE_CYCLES, default 2, range 0..15: cycles the shared resource stays busy after each accepted grant.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 post  input  [0:3]  one-cycle request pulse per requester; may assert any number of bits per cycle.
REQ-005 gnt  input  [0:3]  grant vector from downstream rps4, combinational in the same cycle as req/en.
REQ-006 req  output  [0:3]  req[i]=1 while requester i has pending work; drives rps4 req.
REQ-007 en  output  1  resource free; drives rps4 en.
REQ-008 pend_cnt  output  [0:7]  four 2-bit pending counters packed; bits [2i:2i+1] = requester i.
REQ-009 overflow  output  [0:3]  sticky, post lost at saturation, per requester.
REQ-010 served_id  output  [0:1]  index of the most recently accepted grant.
REQ-011 err  output  1  sticky protocol-violation flag.

Function
REQ-012 req[i] SHALL equal (pend_cnt[i] != 0), combinational from registered counters; no added latency.
REQ-013 en SHALL equal (busy timer == 0), combinational from the registered timer.
REQ-014 A grant is accepted at an edge iff: en=1; gnt is one-hot; req[i]=1 for the granted bit i.
REQ-015 Accepted grant to i: pend_cnt[i] decrements by 1; served_id <= i; timer <= SERVICE_CYCLES.
REQ-016 Timer SHALL decrement by 1 each cycle while nonzero; en is low for exactly SERVICE_CYCLES cycles after the accepting edge.
REQ-017 SERVICE_CYCLES=0: en SHALL stay 1 permanently and back-to-back grants SHALL be accepted on consecutive cycles.
REQ-018 post[i] with no accepted grant to i: pend_cnt[i] increments, saturating at 3.
REQ-019 post[i] with pend_cnt[i]=3 and no accepted grant to i: counter stays 3; overflow[i] <= 1.
REQ-020 post[i] together with an accepted grant to i: counter unchanged, including at 0 is impossible (req=0) and at 3 (no overflow).
REQ-021 post to i SHALL NOT make req[i] visible until the following cycle; a same-cycle grant to i with pend_cnt[i]=0 is a violation.
REQ-022 Violation SHALL be: gnt!=0 while en=0; gnt with >1 bit set; gnt[i]=1 while req[i]=0. On violation: err <= 1; grant ignored (no decrement, no timer load, served_id held).
REQ-023 gnt=0 SHALL be legal in every cycle and cause no state change other than posts and timer countdown.
REQ-024 overflow and err SHALL remain set until reset.

Reset
REQ-025 reset=1 at an edge SHALL clear all pend_cnt, the timer, overflow, err, served_id to 0, overriding post and gnt in that cycle.
REQ-026 After reset: req=4'b0000, en=1, pend_cnt=8'h00, overflow=4'b0000, served_id=2'b00, err=0.
REQ-027 Reset mid-busy SHALL abort the service period; en=1 in the first cycle after reset.

Verification
REQ-028 Reset, post=0001 one cycle -> next cycle req=0001, pend_cnt=00 00 00 01 (req[3] pending); gnt=0001 -> pend back to 0, en low 2 cycles, served_id=3.
REQ-029 post=1111 for 4 consecutive cycles, gnt=0 -> all counters 3, overflow=1111, req=1111, err=0.
REQ-030 pend_cnt[1]=2, en=1, post[1]=1 with gnt=0100 -> pend_cnt[1] stays 2, timer loaded, no overflow.
REQ-031 gnt=0100 while en=0 -> err=1, counters and timer unaffected; gnt=1100 while en=1 -> err=1, no decrement.
REQ-032 SERVICE_CYCLES=0, req=1111, rotating gnt 0001,0010,0100,1000 -> four grants accepted in four consecutive cycles, en constantly 1.
REQ-033 reset asserted one cycle after an accepted grant (timer=1) -> following cycle en=1, req=0000, err=0.
